// File: rtl/register_bank_pkg.sv
// Shared constants for the register bank: geometry and write-counter sizing.
package register_bank_pkg;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  localparam int                CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/register_bank_onehot_check.sv
// Combinational classifier for the decoder's write selector: none, exactly one, or several bits set.
module register_bank_onehot_check #(
  parameter int N = register_bank_pkg::DEPTH
) (
  input  logic [N-1:0] sel_i,
  output logic         is_zero_o,
  output logic         is_onehot_o,
  output logic         multi_o
);

  logic [N-1:0] sel_m1;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign sel_m1      = sel_i - {{(N-1){1'b0}}, 1'b1};
  assign is_zero_o   = (sel_i == '0);
  assign multi_o     = ((sel_i & sel_m1) != '0);
  assign is_onehot_o = !is_zero_o && !multi_o;

endmodule

// File: rtl/register_bank.sv
// 32x32 register storage fed by a registered one-hot write selector, with two
// registered read ports (write-first bypass), a sticky select-error flag and a write counter.
module register_bank #(
  parameter int WIDTH    = register_bank_pkg::WIDTH,
  parameter int DEPTH    = register_bank_pkg::DEPTH,
  parameter int ADDR_W   = register_bank_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DEPTH-1:0]  Selector,
  input  logic [WIDTH-1:0]  WriData,
  input  logic [ADDR_W-1:0] ReadAdd1,
  input  logic [ADDR_W-1:0] ReadAdd2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic              SelError,
  output logic [15:0]       WriteCount
);
  import register_bank_pkg::*;

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  pipe_q;
  logic              arm_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  rd1_q, rd2_q;
  logic [WIDTH-1:0]  rd1_d, rd2_d;

  logic              is_zero, is_onehot, multi;
  logic              commit;
  logic              reg_we;
  logic [ADDR_W-1:0] wr_idx;

  register_bank_onehot_check #(.N(DEPTH)) u_onehot (
    .sel_i       (Selector),
    .is_zero_o   (is_zero),
    .is_onehot_o (is_onehot),
    .multi_o     (multi)
  );

  // Selector may be X until the decoder's first edge, so nothing acts on it before arming.
  assign commit = arm_q && is_onehot && !is_zero;
  assign reg_we = commit && !((ZERO_REG != 0) && (wr_idx == '0));

  always_comb begin
    wr_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Selector[i]) wr_idx = ADDR_W'(i);
    end
  end

  always_comb begin
    rd1_d = regs_q[ReadAdd1];
    if (commit && (wr_idx == ReadAdd1)) rd1_d = pipe_q;
    if ((ZERO_REG != 0) && (ReadAdd1 == '0)) rd1_d = '0;

    rd2_d = regs_q[ReadAdd2];
    if (commit && (wr_idx == ReadAdd2)) rd2_d = pipe_q;
    if ((ZERO_REG != 0) && (ReadAdd2 == '0)) rd2_d = '0;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[wr_idx] <= pipe_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pipe_q <= '0;
      arm_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
    end else begin
      pipe_q <= WriData;
      arm_q  <= 1'b1;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      if (arm_q && multi) err_q <= 1'b1;
      if (commit && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ReadData1  = rd1_q;
  assign ReadData2  = rd2_q;
  assign SelError   = err_q;
  assign WriteCount = cnt_q;

endmodule
